// File: rtl/hazard_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// hazard_sequencer_pkg
//   Shared types for the decode-stage pipeline controller.
//   - state_e : sequencer states (RUN=0, STALL=1, HOLD=2, FLUSH=3)
//   - fwd_e   : operand forward select codes driven on fwda/fwdb
//   - fwd_sel : forward-select priority for one source operand (EXE > MEM)
// -----------------------------------------------------------------------------
package hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,  // register file value
    FWD_EXE  = 2'b01,  // EXE-stage ALU result
    FWD_MEM  = 2'b10,  // MEM-stage ALU result
    FWD_LOAD = 2'b11   // MEM-stage load data
  } fwd_e;

  // A load still in EXE cannot forward; that case is covered by a stall and
  // falls through to the MEM check here.
  function automatic fwd_e fwd_sel(input logic exe_hit, input logic exe_load,
                                   input logic mem_hit, input logic mem_load);
    fwd_e sel;
    sel = FWD_RF;
    if (exe_hit && !exe_load) sel = FWD_EXE;
    else if (mem_hit)         sel = mem_load ? FWD_LOAD : FWD_MEM;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sequencer_reg_match.sv
// -----------------------------------------------------------------------------
// hazard_sequencer_reg_match
//   Compares one ID source register against one downstream destination.
//   Ports:
//     src_i  [4:0] ID source register number
//     use_i        ID instruction actually reads src_i
//     rd_i   [4:0] downstream destination register
//     wreg_i       downstream instruction writes rd_i
//     hit_o        source depends on the downstream result (r0 never matches)
// -----------------------------------------------------------------------------
module hazard_sequencer_reg_match (
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  logic [4:0] rd_i,
  input  logic       wreg_i,
  output logic       hit_o
);

  assign hit_o = use_i && wreg_i && (src_i != 5'd0) && (rd_i == src_i);

endmodule

// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//   Decode-stage pipeline controller: detects RAW hazards against EXE/MEM,
//   sequences stalls, external holds and branch/jump redirect flushes, and
//   drives the PC / pipeline-register enables. Control outputs are
//   combinational from registered state plus current inputs.
//
//   Optional feature: define HAZARD_FWD_EN to enable operand forwarding
//   (fwda/fwdb) and restrict stalls to load-use hazards. Without it fwda/fwdb
//   are tied to 00 and any EXE/MEM dependency stalls.
//
//   Parameters: FLUSH_CYC (IF/ID squash cycles after a taken branch, >=1),
//               STALL_MAX (stall/hold run length tolerated), CNT_W (counter width)
//   Ports:
//     clk, clrn (async, active-high reset)
//     id_rs, id_rt, id_use_rs, id_use_rt, id_jump     : ID stage
//     exe_rd, exe_wreg, exe_m2reg, mem_rd, mem_wreg    : downstream destinations
//     br_taken, ext_hold                               : redirect / front-end freeze
//     pc_we, ifid_we, flush_ifid, bubble_idexe, flush_exemem : pipeline control
//     fwda, fwdb                                       : forward selects
//     stall_cnt, flush_cnt, stall_timeout              : performance / watchdog
// -----------------------------------------------------------------------------
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int FLUSH_CYC = 1,
  parameter int STALL_MAX = 15,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_jump,
  input  logic [4:0]       exe_rd,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic [4:0]       mem_rd,
  input  logic             mem_wreg,
  input  logic             br_taken,
  input  logic             ext_hold,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             flush_ifid,
  output logic             bubble_idexe,
  output logic             flush_exemem,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_timeout
);

  localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int RUN_W = $clog2(STALL_MAX + 2);
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYC - 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(STALL_MAX);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(STALL_MAX + 1);

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic exe_rs_hit, exe_rt_hit, mem_rs_hit, mem_rt_hit;
  logic hz, is_stall, is_redirect, in_flush;
  fwd_e fwda_raw, fwdb_raw;

  hazard_sequencer_reg_match u_exe_rs (.src_i(id_rs), .use_i(id_use_rs), .rd_i(exe_rd),
                                       .wreg_i(exe_wreg), .hit_o(exe_rs_hit));
  hazard_sequencer_reg_match u_exe_rt (.src_i(id_rt), .use_i(id_use_rt), .rd_i(exe_rd),
                                       .wreg_i(exe_wreg), .hit_o(exe_rt_hit));
  hazard_sequencer_reg_match u_mem_rs (.src_i(id_rs), .use_i(id_use_rs), .rd_i(mem_rd),
                                       .wreg_i(mem_wreg), .hit_o(mem_rs_hit));
  hazard_sequencer_reg_match u_mem_rt (.src_i(id_rt), .use_i(id_use_rt), .rd_i(mem_rd),
                                       .wreg_i(mem_wreg), .hit_o(mem_rt_hit));

`ifdef HAZARD_FWD_EN
  // Tracks whether the instruction now in MEM was a load one cycle ago.
  logic mem_load_q;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) mem_load_q <= 1'b0;
    else      mem_load_q <= exe_m2reg;
  end

  assign hz       = (exe_rs_hit || exe_rt_hit) && exe_m2reg;
  assign fwda_raw = fwd_sel(exe_rs_hit, exe_m2reg, mem_rs_hit, mem_load_q);
  assign fwdb_raw = fwd_sel(exe_rt_hit, exe_m2reg, mem_rt_hit, mem_load_q);
`else
  logic unused_m2reg;
  assign unused_m2reg = exe_m2reg;
  assign hz       = exe_rs_hit || exe_rt_hit || mem_rs_hit || mem_rt_hit;
  assign fwda_raw = FWD_RF;
  assign fwdb_raw = FWD_RF;
`endif

  // A hold arriving mid-flush keeps the remaining squash count and resumes it.
  assign in_flush = (state_q == FLUSH) || ((state_q == HOLD) && (fcnt_q != '0));

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    flush_ifid   = 1'b0;
    bubble_idexe = 1'b0;
    flush_exemem = 1'b0;
    fwda         = fwda_raw;
    fwdb         = fwdb_raw;
    state_d      = RUN;
    fcnt_d       = fcnt_q;
    is_stall     = 1'b0;
    is_redirect  = 1'b0;

    if (clrn) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      bubble_idexe = 1'b1;
      fwda         = FWD_RF;
      fwdb         = FWD_RF;
      fcnt_d       = '0;
    end else if (br_taken) begin
      flush_ifid   = 1'b1;
      bubble_idexe = 1'b1;
      flush_exemem = 1'b1;
      is_redirect  = 1'b1;
      fcnt_d       = FC_LOAD;
      state_d      = (FLUSH_CYC > 1) ? FLUSH : RUN;
    end else if (ext_hold) begin
      // Downstream stays frozen too, so no bubble is inserted.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      is_stall = 1'b1;
      state_d  = HOLD;
    end else if (in_flush) begin
      flush_ifid = 1'b1;
      fcnt_d     = fcnt_q - FC_W'(1);
      state_d    = (fcnt_q == FC_W'(1)) ? RUN : FLUSH;
    end else if (hz) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      bubble_idexe = 1'b1;
      is_stall     = 1'b1;
      state_d      = STALL;
    end else if (id_jump) begin
      flush_ifid = 1'b1;  // squash the delay-slot fetch
    end
  end

  always_comb begin
    run_d       = '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (is_stall) begin
      run_d = (run_q == RUN_SAT) ? run_q : run_q + RUN_W'(1);
      if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (is_redirect && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    timeout_d = timeout_q || (run_d > RUN_LIM);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      run_q       <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      run_q       <= run_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
//   Directed bench for hazard_sequencer with FLUSH_CYC=3, STALL_MAX=15.
//   Expected values are hand-derived; forwarding-dependent expectations
//   follow HAZARD_FWD_EN.
//   ctl = {pc_we, ifid_we, flush_ifid, bubble_idexe, flush_exemem}
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [4:0] C_RST   = 5'b00010;
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_HOLD  = 5'b00000;
  localparam logic [4:0] C_REDIR = 5'b11111;
  localparam logic [4:0] C_FLUSH = 5'b11100;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  id_rs, id_rt, exe_rd, mem_rd;
  logic        id_use_rs, id_use_rt, id_jump, exe_wreg, exe_m2reg, mem_wreg;
  logic        br_taken, ext_hold;
  logic        pc_we, ifid_we, flush_ifid, bubble_idexe, flush_exemem, stall_timeout;
  logic [1:0]  fwda, fwdb;
  logic [31:0] stall_cnt, flush_cnt;
  logic [4:0]  ctl;

  int vectors     = 0;
  int miscompares = 0;
  int exp_stall   = 0;
  int exp_flush   = 0;

  assign ctl = {pc_we, ifid_we, flush_ifid, bubble_idexe, flush_exemem};

  always #5 clk = ~clk;

  hazard_sequencer #(.FLUSH_CYC(3), .STALL_MAX(15), .CNT_W(32)) dut (
    .clk(clk), .clrn(clrn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_jump(id_jump), .exe_rd(exe_rd), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
    .mem_rd(mem_rd), .mem_wreg(mem_wreg), .br_taken(br_taken), .ext_hold(ext_hold),
    .pc_we(pc_we), .ifid_we(ifid_we), .flush_ifid(flush_ifid),
    .bubble_idexe(bubble_idexe), .flush_exemem(flush_exemem),
    .fwda(fwda), .fwdb(fwdb), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .stall_timeout(stall_timeout)
  );

  // Advance one rising edge, then let inputs settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_jump = 1'b0;
    exe_rd = 5'd0; exe_wreg = 1'b0; exe_m2reg = 1'b0;
    mem_rd = 5'd0; mem_wreg = 1'b0; br_taken = 1'b0; ext_hold = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b1;
    idle();
    vectors++;
    if (ctl !== C_RST) begin
      miscompares++; $display("FAIL reset_ctl got %b want %b", ctl, C_RST);
    end
    vectors++;
    if ({fwda, fwdb, stall_timeout} !== 5'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state got fwd=%b%b to=%b sc=%0d fc=%0d want zeros",
               fwda, fwdb, stall_timeout, stall_cnt, flush_cnt);
    end
    step(); step();
    clrn = 1'b0;
    #1;
    vectors++;
    if (ctl !== C_RUN) begin
      miscompares++; $display("FAIL reset_release_ctl got %b want %b", ctl, C_RUN);
    end
  endtask

  // add r3 in EXE then MEM, ID reads r3.
  task automatic test_raw_hazard();
    id_rs = 5'd3; id_use_rs = 1'b1; exe_rd = 5'd3; exe_wreg = 1'b1;
    #1;
    vectors++;
    if (ctl !== (FWD ? C_RUN : C_STALL) || fwda !== (FWD ? 2'b01 : 2'b00)) begin
      miscompares++;
      $display("FAIL raw_exe got ctl=%b fwda=%b want ctl=%b fwda=%b", ctl, fwda,
               FWD ? C_RUN : C_STALL, FWD ? 2'b01 : 2'b00);
    end
    if (!FWD) exp_stall++;
    step();
    exe_wreg = 1'b0; mem_rd = 5'd3; mem_wreg = 1'b1;
    #1;
    vectors++;
    if (ctl !== (FWD ? C_RUN : C_STALL) || fwda !== (FWD ? 2'b10 : 2'b00)) begin
      miscompares++;
      $display("FAIL raw_mem got ctl=%b fwda=%b want ctl=%b fwda=%b", ctl, fwda,
               FWD ? C_RUN : C_STALL, FWD ? 2'b10 : 2'b00);
    end
    if (!FWD) exp_stall++;
    step();
    idle();
    vectors++;
    if (ctl !== C_RUN || stall_cnt !== 32'(exp_stall)) begin
      miscompares++;
      $display("FAIL raw_done got ctl=%b stall_cnt=%0d want ctl=%b stall_cnt=%0d",
               ctl, stall_cnt, C_RUN, exp_stall);
    end
    // r0 and an unused source never create a dependency.
    id_rs = 5'd0; id_use_rs = 1'b1; exe_rd = 5'd0; exe_wreg = 1'b1;
    id_rt = 5'd9; id_use_rt = 1'b0; mem_rd = 5'd9; mem_wreg = 1'b1;
    #1;
    vectors++;
    if (ctl !== C_RUN || {fwda, fwdb} !== 4'b0000) begin
      miscompares++;
      $display("FAIL r0_unused got ctl=%b fwd=%b%b want ctl=%b fwd=0000", ctl, fwda, fwdb, C_RUN);
    end
    step();
    idle();
    // rt path through EXE.
    id_rt = 5'd7; id_use_rt = 1'b1; exe_rd = 5'd7; exe_wreg = 1'b1;
    #1;
    vectors++;
    if (ctl !== (FWD ? C_RUN : C_STALL) || fwdb !== (FWD ? 2'b01 : 2'b00)) begin
      miscompares++;
      $display("FAIL raw_rt got ctl=%b fwdb=%b want ctl=%b fwdb=%b", ctl, fwdb,
               FWD ? C_RUN : C_STALL, FWD ? 2'b01 : 2'b00);
    end
    if (!FWD) exp_stall++;
    step();
    idle();
  endtask

  // lw r5 in EXE, ID uses r5.
  task automatic test_load_use();
    id_rs = 5'd5; id_use_rs = 1'b1; exe_rd = 5'd5; exe_wreg = 1'b1; exe_m2reg = 1'b1;
    #1;
    vectors++;
    if (ctl !== C_STALL || fwda !== 2'b00) begin
      miscompares++;
      $display("FAIL load_use_stall got ctl=%b fwda=%b want ctl=%b fwda=00", ctl, fwda, C_STALL);
    end
    exp_stall++;
    step();
    exe_wreg = 1'b0; exe_m2reg = 1'b0; mem_rd = 5'd5; mem_wreg = 1'b1;
    #1;
    vectors++;
    if (ctl !== (FWD ? C_RUN : C_STALL) || fwda !== (FWD ? 2'b11 : 2'b00)) begin
      miscompares++;
      $display("FAIL load_use_fwd got ctl=%b fwda=%b want ctl=%b fwda=%b", ctl, fwda,
               FWD ? C_RUN : C_STALL, FWD ? 2'b11 : 2'b00);
    end
    if (!FWD) exp_stall++;
    step();
    idle();
  endtask

  task automatic test_jump();
    id_jump = 1'b1;
    #1;
    vectors++;
    if (ctl !== C_FLUSH) begin
      miscompares++; $display("FAIL jump_squash got %b want %b", ctl, C_FLUSH);
    end
    step();
    idle();
    vectors++;
    if (ctl !== C_RUN) begin
      miscompares++; $display("FAIL jump_after got %b want %b", ctl, C_RUN);
    end
  endtask

  // Taken branch with FLUSH_CYC=3: redirect cycle plus two FLUSH cycles.
  task automatic test_branch_flush();
    logic [4:0] exp_seq [4];
    exp_seq[0] = C_REDIR; exp_seq[1] = C_FLUSH; exp_seq[2] = C_FLUSH; exp_seq[3] = C_RUN;
    br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (ctl !== exp_seq[i]) begin
        miscompares++; $display("FAIL branch_flush[%0d] got %b want %b", i, ctl, exp_seq[i]);
      end
      step();
      br_taken = 1'b0;
    end
    exp_flush++;
    vectors++;
    if (flush_cnt !== 32'(exp_flush)) begin
      miscompares++; $display("FAIL branch_flush_cnt got %0d want %0d", flush_cnt, exp_flush);
    end
  endtask

  // Redirect beats hold and hazard; hold beats hazard.
  task automatic test_priority();
    br_taken = 1'b1; ext_hold = 1'b1;
    id_rs = 5'd3; id_use_rs = 1'b1; exe_rd = 5'd3; exe_wreg = 1'b1; exe_m2reg = 1'b1;
    #1;
    vectors++;
    if (ctl !== C_REDIR) begin
      miscompares++; $display("FAIL prio_branch got %b want %b", ctl, C_REDIR);
    end
    exp_flush++;
    step();
    idle();
    vectors++;
    if (ctl !== C_FLUSH || flush_cnt !== 32'(exp_flush)) begin
      miscompares++;
      $display("FAIL prio_flush_state got ctl=%b fc=%0d want ctl=%b fc=%0d",
               ctl, flush_cnt, C_FLUSH, exp_flush);
    end
    step(); step();
    ext_hold = 1'b1;
    id_rs = 5'd3; id_use_rs = 1'b1; exe_rd = 5'd3; exe_wreg = 1'b1; exe_m2reg = 1'b1;
    #1;
    vectors++;
    if (ctl !== C_HOLD) begin
      miscompares++; $display("FAIL prio_hold got %b want %b", ctl, C_HOLD);
    end
    exp_stall++;
    step();
    idle();
    vectors++;
    if (ctl !== C_RUN || stall_cnt !== 32'(exp_stall)) begin
      miscompares++;
      $display("FAIL prio_after got ctl=%b sc=%0d want ctl=%b sc=%0d",
               ctl, stall_cnt, C_RUN, exp_stall);
    end
  endtask

  // 16 consecutive hold cycles against STALL_MAX=15.
  task automatic test_timeout();
    step();
    ext_hold = 1'b1;
    for (int i = 0; i < 15; i++) step();
    vectors++;
    if (stall_timeout !== 1'b0) begin
      miscompares++; $display("FAIL timeout_15 got %b want 0", stall_timeout);
    end
    step();
    vectors++;
    if (stall_timeout !== 1'b1) begin
      miscompares++; $display("FAIL timeout_16 got %b want 1", stall_timeout);
    end
    exp_stall += 16;
    ext_hold = 1'b0;
    step(); step();
    vectors++;
    if (stall_timeout !== 1'b1 || ctl !== C_RUN || stall_cnt !== 32'(exp_stall)) begin
      miscompares++;
      $display("FAIL timeout_sticky got to=%b ctl=%b sc=%0d want to=1 ctl=%b sc=%0d",
               stall_timeout, ctl, stall_cnt, C_RUN, exp_stall);
    end
  endtask

  task automatic test_reset_mid_flush();
    br_taken = 1'b1;
    step();
    br_taken = 1'b0;
    #1;
    vectors++;
    if (ctl !== C_FLUSH) begin
      miscompares++; $display("FAIL midflush_pre got %b want %b", ctl, C_FLUSH);
    end
    #2;
    clrn = 1'b1;
    #1;
    vectors++;
    if (ctl !== C_RST || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || stall_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL midflush_reset got ctl=%b sc=%0d fc=%0d to=%b want ctl=%b zeros",
               ctl, stall_cnt, flush_cnt, stall_timeout, C_RST);
    end
    step();
    clrn = 1'b0;
    #1;
    vectors++;
    if (ctl !== C_RUN) begin
      miscompares++; $display("FAIL midflush_release got %b want %b", ctl, C_RUN);
    end
    step();
    vectors++;
    if (ctl !== C_RUN || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL midflush_after got ctl=%b sc=%0d fc=%0d want ctl=%b zeros",
               ctl, stall_cnt, flush_cnt, C_RUN);
    end
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_load_use();
    test_jump();
    test_branch_flush();
    test_priority();
    test_timeout();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
